branch_predictor: RTL and testbench

Bimodal branch predictor for the two-stage fetch/issue pipeline: a table of 2-bit saturating counters indexed by fetch PC. It supplies the `prediction` bit that the issue-stage branch comparator consumes, carries that prediction and its table index into the issue stage, and trains the counter from the comparator's resolution outputs (`branchTaken`, `falseTaken`, `falseNotTaken`). It also raises a single-cycle mispredict pulse for the fetch redirect logic.

---
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by fetch PC, with an IF->IS register.
// Define BP_STATS_EN to add saturating resolved-branch and mispredict counters.
module branch_predictor #(
    parameter int unsigned IDX_BITS   = 6,
    parameter int unsigned PC_WIDTH   = 32,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] pc_IF,
    input  logic                fetchValid,
    input  logic                stall,
    input  logic                flush,
    output logic                prediction,
    output logic                prediction_IS,
    input  logic                resolveValid,
    input  logic                branchTaken,
    input  logic                falseTaken,
    input  logic                falseNotTaken,
    output logic                mispredict
`ifdef BP_STATS_EN
    ,
    output logic [31:0]         branchCount,
    output logic [31:0]         mispredictCount
`endif
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    logic [1:0]          cnt_q [ENTRIES];
    logic [1:0]          cnt_cur;
    logic [1:0]          cnt_d;
    logic [IDX_BITS-1:0] idx;
    logic [IDX_BITS-1:0] idx_IS_q, idx_IS_d;
    logic                pred_IS_q, pred_IS_d;
    logic                valid_IS_q, valid_IS_d;
    logic                upd;
    logic                unused_pc;

    assign idx       = pc_IF[IDX_BITS+1:2];
    assign unused_pc = ^{pc_IF[PC_WIDTH-1:IDX_BITS+2], pc_IF[1:0]};

    // Lookup reads the registered table, so a same-index update is not bypassed.
    assign prediction    = fetchValid & cnt_q[idx][1];
    assign prediction_IS = pred_IS_q;

    assign upd        = resolveValid & valid_IS_q & ~stall;
    assign mispredict = upd & (falseTaken | falseNotTaken);
    assign cnt_cur    = cnt_q[idx_IS_q];

    always_comb begin
        cnt_d = cnt_cur;
        if (branchTaken) begin
            if (cnt_cur != 2'b11) cnt_d = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != 2'b00) cnt_d = cnt_cur - 2'd1;
        end
    end

    always_comb begin
        idx_IS_d   = idx_IS_q;
        pred_IS_d  = pred_IS_q;
        valid_IS_d = valid_IS_q;
        // Flush wins over stall; the index is left as-is since valid is cleared.
        if (flush) begin
            pred_IS_d  = 1'b0;
            valid_IS_d = 1'b0;
        end else if (!stall) begin
            idx_IS_d   = idx;
            pred_IS_d  = prediction;
            valid_IS_d = fetchValid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_IS_q   <= '0;
            pred_IS_q  <= 1'b0;
            valid_IS_q <= 1'b0;
        end else begin
            idx_IS_q   <= idx_IS_d;
            pred_IS_q  <= pred_IS_d;
            valid_IS_q <= valid_IS_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= INIT_STATE;
        end else if (upd) begin
            cnt_q[idx_IS_q] <= cnt_d;
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (upd && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign branchCount     = branch_cnt_q;
    assign mispredictCount = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor plus hand sequences for reset and stats.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_IF;
    logic        fetchValid, stall, flush;
    logic        prediction, prediction_IS;
    logic        resolveValid, branchTaken, falseTaken, falseNotTaken;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] branchCount, mispredictCount;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor #(.IDX_BITS(6), .PC_WIDTH(32), .INIT_STATE(2'b01)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_IF         (pc_IF),
        .fetchValid    (fetchValid),
        .stall         (stall),
        .flush         (flush),
        .prediction    (prediction),
        .prediction_IS (prediction_IS),
        .resolveValid  (resolveValid),
        .branchTaken   (branchTaken),
        .falseTaken    (falseTaken),
        .falseNotTaken (falseNotTaken),
        .mispredict    (mispredict)
`ifdef BP_STATS_EN
        ,
        .branchCount   (branchCount),
        .mispredictCount(mispredictCount)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic fv, st, fl, rv, bt, ft, fnt;
        logic u;
        logic ep, epis, em;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [31:0] pc, input logic fv, st, fl, rv, bt, ft, fnt,
                                input logic u, ep, epis, em);
        vec_t v;
        v.pc = pc; v.fv = fv; v.st = st; v.fl = fl; v.rv = rv; v.bt = bt; v.ft = ft; v.fnt = fnt;
        v.u = u; v.ep = ep; v.epis = epis; v.em = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic fv, st, fl, rv, bt, ft, fnt);
        pc_IF = pc; fetchValid = fv; stall = st; flush = fl;
        resolveValid = rv; branchTaken = bt; falseTaken = ft; falseNotTaken = fnt;
    endtask

    task automatic check_outs(input string tag, input logic ep, epis, em);
        chk({tag, " prediction"}, {31'd0, prediction}, {31'd0, ep});
        chk({tag, " prediction_IS"}, {31'd0, prediction_IS}, {31'd0, epis});
        chk({tag, " mispredict"}, {31'd0, mispredict}, {31'd0, em});
    endtask

    int exp_branches;
    int exp_mispred;

    initial begin
        // pc, fv, st, fl, rv, bt, ft, fnt, upd, exp pred, exp pred_IS, exp mispredict
        vecs.push_back(mk(32'h040, 1,0,0, 0,0,0,0, 0, 0,0,0)); // r0
        vecs.push_back(mk(32'h040, 1,0,0, 1,1,0,1, 1, 0,0,1)); // r1 cnt 1->2
        vecs.push_back(mk(32'h040, 1,0,0, 1,1,0,1, 1, 1,0,1)); // r2 cnt 2->3
        vecs.push_back(mk(32'h040, 1,0,0, 1,1,0,0, 1, 1,1,0)); // r3 saturate
        vecs.push_back(mk(32'h040, 1,0,0, 1,1,0,0, 1, 1,1,0)); // r4 saturate
        vecs.push_back(mk(32'h040, 1,0,0, 1,0,1,0, 1, 1,1,1)); // r5 cnt 3->2
        vecs.push_back(mk(32'h040, 1,0,0, 1,0,1,0, 1, 1,1,1)); // r6 cnt 2->1
        vecs.push_back(mk(32'h040, 1,0,0, 0,0,0,0, 0, 0,1,0)); // r7
        vecs.push_back(mk(32'h040, 0,0,0, 0,0,0,0, 0, 0,0,0)); // r8 bubble into IS
        vecs.push_back(mk(32'h040, 0,0,0, 1,1,0,1, 0, 0,0,0)); // r9 resolve ignored
        vecs.push_back(mk(32'h040, 1,0,0, 0,0,0,0, 0, 0,0,0)); // r10 cnt still 1
        vecs.push_back(mk(32'h040, 1,1,0, 1,1,0,1, 0, 0,0,0)); // r11 stalled: no mispredict
        vecs.push_back(mk(32'h040, 0,0,0, 1,1,0,1, 1, 0,0,1)); // r12 cnt 1->2
        vecs.push_back(mk(32'h040, 1,0,0, 1,1,0,1, 0, 1,0,0)); // r13 IS invalid: ignored
        vecs.push_back(mk(32'h020, 1,0,0, 0,0,0,0, 0, 0,1,0)); // r14 idx 8 into IS
        vecs.push_back(mk(32'h080, 1,1,0, 1,1,0,1, 0, 0,0,0)); // r15 stall
        vecs.push_back(mk(32'h080, 1,1,0, 1,1,0,1, 0, 0,0,0)); // r16 stall
        vecs.push_back(mk(32'h080, 1,1,0, 1,1,0,1, 0, 0,0,0)); // r17 stall
        vecs.push_back(mk(32'h020, 1,0,0, 1,1,0,1, 1, 0,0,1)); // r18 one increment 1->2
        vecs.push_back(mk(32'h020, 1,0,0, 1,0,0,0, 1, 1,0,0)); // r19 2->1
        vecs.push_back(mk(32'h020, 1,0,0, 0,0,0,0, 0, 0,1,0)); // r20
        vecs.push_back(mk(32'h020, 1,0,1, 1,1,0,1, 1, 0,0,1)); // r21 flush with upd: 1->2
        vecs.push_back(mk(32'h020, 1,0,0, 1,1,0,1, 0, 1,0,0)); // r22 IS cleared
        vecs.push_back(mk(32'h020, 1,1,1, 0,0,0,0, 0, 1,1,0)); // r23 flush beats stall
        vecs.push_back(mk(32'h020, 1,0,0, 1,0,1,0, 0, 1,0,0)); // r24 IS cleared
        vecs.push_back(mk(32'h004, 1,0,0, 0,0,0,0, 0, 0,1,0)); // r25 idx 1
        vecs.push_back(mk(32'h104, 1,0,0, 1,1,0,1, 1, 0,0,1)); // r26 alias, no bypass
        vecs.push_back(mk(32'h104, 1,0,0, 1,1,0,1, 1, 1,0,1)); // r27
        vecs.push_back(mk(32'h004, 1,0,0, 0,0,0,0, 0, 1,1,0)); // r28 shared entry taken
        vecs.push_back(mk(32'h004, 0,0,0, 0,0,0,0, 0, 0,1,0)); // r29

        rst_n = 1'b0;
        drive(32'h0, 0,0,0, 0,0,0,0);

        // Outputs while held in reset, with active-looking inputs.
        @(negedge clk);
        drive(32'h040, 1,0,0, 1,1,0,1);
        #1 check_outs("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h0, 0,0,0, 0,0,0,0);
        rst_n = 1'b1;
`ifdef BP_STATS_EN
        #1;
        chk("reset branchCount", branchCount, 32'd0);
        chk("reset mispredictCount", mispredictCount, 32'd0);
`endif

        exp_branches = 0;
        exp_mispred  = 0;
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].pc, vecs[i].fv, vecs[i].st, vecs[i].fl,
                  vecs[i].rv, vecs[i].bt, vecs[i].ft, vecs[i].fnt);
            #1 check_outs($sformatf("r%0d", i), vecs[i].ep, vecs[i].epis, vecs[i].em);
            exp_branches += int'(vecs[i].u);
            exp_mispred  += int'(vecs[i].em);
        end

        @(negedge clk);
        drive(32'h004, 1,0,0, 0,0,0,0);
        #1 chk("trained idx1 pred", {31'd0, prediction}, 32'd1);
`ifdef BP_STATS_EN
        chk("table branchCount", branchCount, 32'(exp_branches));
        chk("table mispredictCount", mispredictCount, 32'(exp_mispred));
`endif

        // Mid-run asynchronous reset discards training.
        #2 rst_n = 1'b0;
        #1 check_outs("midreset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h004, 1,0,0, 0,0,0,0);
        #1 check_outs("post-reset idx1", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h020, 1,0,0, 0,0,0,0);
        #1 check_outs("post-reset idx8", 1'b0, 1'b0, 1'b0);
`ifdef BP_STATS_EN
        chk("post-reset branchCount", branchCount, 32'd0);
        chk("post-reset mispredictCount", mispredictCount, 32'd0);
`endif

        // Ten resolved branches, three flagged as mispredicted.
        @(negedge clk);
        drive(32'h040, 1,0,0, 0,0,0,0);
        #1 check_outs("s0", 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            logic m;
            m = (i == 2 || i == 5 || i == 7);
            @(negedge clk);
            drive(32'h040, 1,0,0, 1,0,0,m);
            #1 check_outs($sformatf("s%0d", i), 1'b0, 1'b0, m);
        end
        @(negedge clk);
        drive(32'h0, 0,0,0, 0,0,0,0);
        #1;
`ifdef BP_STATS_EN
        chk("stats branchCount", branchCount, 32'd10);
        chk("stats mispredictCount", mispredictCount, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
